// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared AHB encodings for the ahb2apb bridge subsystem, plus burst-length helpers
// used by the bus arbiter.
package ahb_apb_bridge_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } trans_type_t;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001,
    BURST_WRAP4  = 3'b010,
    BURST_INCR4  = 3'b011,
    BURST_WRAP8  = 3'b100,
    BURST_INCR8  = 3'b101,
    BURST_WRAP16 = 3'b110,
    BURST_INCR16 = 3'b111
  } burst_type_t;

  typedef logic [4:0] beats_t;

  // Zero means undefined length (INCR).
  function automatic beats_t burst_beats(burst_type_t burst);
    case (burst)
      BURST_SINGLE:               return 5'd1;
      BURST_WRAP4,  BURST_INCR4:  return 5'd4;
      BURST_WRAP8,  BURST_INCR8:  return 5'd8;
      BURST_WRAP16, BURST_INCR16: return 5'd16;
      default:                    return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Request/grant and shared-bus signals between the requesting masters and the arbiter.
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = $clog2(NUM_MASTERS)
);
  import ahb_apb_bridge_pkg::*;

  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  trans_type_t            HTRANS;
  burst_type_t            HBURST;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [MW-1:0]          HMASTER;
  logic                   HMASTLOCK;

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    output HGRANT, HMASTER, HMASTLOCK
  );

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    input  HGRANT, HMASTER, HMASTLOCK
  );

endinterface

// File: rtl/ahb_bus_arbiter_rr_pick.sv
// Combinational circular first-one finder: lowest set bit of req at or after start,
// wrapping around the top of the vector.
module rr_pick #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MW-1:0]          start,
  output logic                   found,
  output logic [MW-1:0]          index
);

  // Walk offsets from farthest to nearest so the nearest requester overwrites the result.
  always_comb begin
    int pos;
    found = 1'b0;
    index = '0;
    pos   = 0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      pos = (int'(start) + i) % NUM_MASTERS;
      if (req[pos[MW-1:0]]) begin
        found = 1'b1;
        index = pos[MW-1:0];
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter: tracks burst progress on the shared bus and moves the grant
// only at burst boundaries, honouring HLOCK and parking on DEFAULT_MASTER.
module ahb_bus_arbiter
  import ahb_apb_bridge_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = $clog2(NUM_MASTERS)
) (
  input  logic            HCLK,
  input  logic            HRESET,
  ahb_bus_arbiter_if.slave bus
);

  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

  beats_t                 rem, rem_next, beats;
  logic                   undef, undef_next;
  logic [MW-1:0]          owner, start, pick, next_owner;
  logic                   found, arb_point;
  logic [NUM_MASTERS-1:0] grant;
  logic [MW-1:0]          hmaster;
  logic                   hmastlock;

  assign beats = burst_beats(bus.HBURST);

  always_comb begin
    rem_next   = rem;
    undef_next = undef;
    case (bus.HTRANS)
      TRANS_NONSEQ: begin
        if (beats != 5'd0) begin
          rem_next   = beats - 5'd1;
          undef_next = 1'b0;
        end else begin
          rem_next   = 5'd0;
          undef_next = 1'b1;
        end
      end
      TRANS_SEQ: begin
        if (rem != 5'd0) rem_next = rem - 5'd1;
      end
      TRANS_IDLE: begin
        rem_next   = 5'd0;
        undef_next = 1'b0;
      end
      default: ;
    endcase
  end

  // The owner index doubles as the round-robin pointer; the search starts just past it.
  assign start = (owner == MW'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;

  rr_pick #(.NUM_MASTERS(NUM_MASTERS), .MW(MW)) u_pick (
    .req   (bus.HBUSREQ),
    .start (start),
    .found (found),
    .index (pick)
  );

  // The burst state after this edge decides the boundary, so an INCR opening beat is
  // already treated as undefined length and cannot be pre-empted.
  always_comb begin
    arb_point = bus.HREADY && (bus.HTRANS != TRANS_BUSY) &&
                ((!undef_next && (rem_next == 5'd0)) ||
                 (undef_next && !bus.HBUSREQ[owner]));
    next_owner = owner;
    if (bus.HLOCK[owner] && bus.HBUSREQ[owner]) next_owner = owner;
    else if (found)                             next_owner = pick;
    else                                        next_owner = DEF_IDX;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rem       <= 5'd0;
      undef     <= 1'b0;
      owner     <= DEF_IDX;
      grant     <= NUM_MASTERS'(1) << DEF_IDX;
      hmaster   <= DEF_IDX;
      hmastlock <= 1'b0;
    end else if (bus.HREADY) begin
      rem       <= rem_next;
      undef     <= undef_next;
      hmaster   <= owner;
      hmastlock <= bus.HLOCK[owner];
      if (arb_point) begin
        owner <= next_owner;
        grant <= NUM_MASTERS'(1) << next_owner;
      end
    end
  end

  assign bus.HGRANT    = grant;
  assign bus.HMASTER   = hmaster;
  assign bus.HMASTLOCK = hmastlock;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: stimulus queues hand-computed expectations
// tagged with the cycle they apply to; a negedge monitor pops and compares them.
module tb_ahb_bus_arbiter;
  import ahb_apb_bridge_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb_bus_arbiter_if #(.NUM_MASTERS(4)) bus ();

  ahb_bus_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus)
  );

  typedef struct {
    int         cyc;
    string      name;
    bit         cg;
    logic [3:0] g;
    bit         cm;
    logic [1:0] m;
    logic       l;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc_count = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc_count <= cyc_count + 1;

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, act, req, cyc_count);
    end
  endtask

  // Monitor: compare every expectation that is due for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_count) begin
      cur = sb.pop_front();
      if (cur.cg) checkOutput({cur.name, ".grant"}, bus.HGRANT, cur.g);
      if (cur.cm) begin
        checkOutput({cur.name, ".master"}, {2'b00, bus.HMASTER}, {2'b00, cur.m});
        checkOutput({cur.name, ".lock"}, {3'b000, bus.HMASTLOCK}, {3'b000, cur.l});
      end
    end
  end

  // Drive one bus cycle; the expectation applies after the edge that samples it.
  task automatic applyStimulus(input string name, input logic [3:0] req, input logic [3:0] lock,
                               input trans_type_t tr, input burst_type_t bu, input logic rdy,
                               input bit cg, input logic [3:0] g,
                               input bit cm, input logic [1:0] m, input logic l);
    @(posedge clk);
    #1;
    bus.HBUSREQ = req;
    bus.HLOCK   = lock;
    bus.HTRANS  = tr;
    bus.HBURST  = bu;
    bus.HREADY  = rdy;
    if (cg || cm) sb.push_back('{cyc_count + 1, name, cg, g, cm, m, l});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int own;
    int nxt;
    bus.HBUSREQ = 4'b0000;
    bus.HLOCK   = 4'b0000;
    bus.HTRANS  = TRANS_IDLE;
    bus.HBURST  = BURST_SINGLE;
    bus.HREADY  = 1'b1;

    repeat (2) @(posedge clk);
    #2;
    sb.push_back('{cyc_count, "in_reset", 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0});
    @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 10; k++)
      applyStimulus("idle_park", 4'b0000, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1,
                    1, 4'b0001, 1, 2'd0, 1'b0);

    applyStimulus("m1_req",     4'b0010, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1'b1, 1, 4'b0010, 1, 2'd0, 1'b0);
    applyStimulus("m1_hold",    4'b0010, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1'b1, 1, 4'b0010, 1, 2'd1, 1'b0);
    applyStimulus("incr4_b1",   4'b0110, 4'b0000, TRANS_NONSEQ, BURST_INCR4,  1'b1, 1, 4'b0010, 1, 2'd1, 1'b0);
    applyStimulus("incr4_b2",   4'b0110, 4'b0000, TRANS_SEQ,    BURST_INCR4,  1'b1, 1, 4'b0010, 1, 2'd1, 1'b0);
    applyStimulus("incr4_b3",   4'b0110, 4'b0000, TRANS_SEQ,    BURST_INCR4,  1'b1, 1, 4'b0010, 1, 2'd1, 1'b0);
    applyStimulus("incr4_b4",   4'b0110, 4'b0000, TRANS_SEQ,    BURST_INCR4,  1'b1, 1, 4'b0100, 1, 2'd1, 1'b0);
    applyStimulus("m2_master",  4'b0100, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1'b1, 1, 4'b0100, 1, 2'd2, 1'b0);

    own = 2;
    for (int k = 0; k < 9; k++) begin
      nxt = (own + 1) % 4;
      applyStimulus("rotate", 4'b1111, 4'b0000, TRANS_NONSEQ, BURST_SINGLE, 1'b1,
                    1, 4'b0001 << nxt, 1, own[1:0], 1'b0);
      own = nxt;
    end

    applyStimulus("lock_arb", 4'b1001, 4'b1000, TRANS_IDLE, BURST_SINGLE, 1'b1, 1, 4'b1000, 1, 2'd3, 1'b1);
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 8; k++) begin
        if (b == 1 && k == 7)
          applyStimulus("lock_release", 4'b1001, 4'b0000, TRANS_SEQ, BURST_INCR8, 1'b1,
                        1, 4'b0001, 1, 2'd3, 1'b0);
        else
          applyStimulus("lock_hold", 4'b1001, 4'b1000, (k == 0) ? TRANS_NONSEQ : TRANS_SEQ,
                        BURST_INCR8, 1'b1, 1, 4'b1000, 1, 2'd3, 1'b1);
      end
    end
    applyStimulus("m0_master", 4'b0001, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, 1, 4'b0001, 1, 2'd0, 1'b0);

    applyStimulus("m1_req2",   4'b0010, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1'b1, 1, 4'b0010, 1, 2'd0, 1'b0);
    applyStimulus("m1_hold2",  4'b0010, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1'b1, 1, 4'b0010, 1, 2'd1, 1'b0);
    applyStimulus("incr8_b1",  4'b0110, 4'b0000, TRANS_NONSEQ, BURST_INCR8,  1'b1, 1, 4'b0010, 1, 2'd1, 1'b0);
    for (int k = 0; k < 3; k++)
      applyStimulus("incr8_seq", 4'b0110, 4'b0000, TRANS_SEQ, BURST_INCR8, 1'b1, 1, 4'b0010, 1, 2'd1, 1'b0);
    for (int k = 0; k < 3; k++)
      applyStimulus("incr8_wait", 4'b0110, 4'b0000, TRANS_SEQ, BURST_INCR8, 1'b0, 1, 4'b0010, 1, 2'd1, 1'b0);
    applyStimulus("incr8_b5",  4'b0110, 4'b0000, TRANS_SEQ,    BURST_INCR8,  1'b1, 1, 4'b0010, 1, 2'd1, 1'b0);
    applyStimulus("incr8_busy",4'b0110, 4'b0000, TRANS_BUSY,   BURST_INCR8,  1'b1, 1, 4'b0010, 1, 2'd1, 1'b0);
    applyStimulus("incr8_b6",  4'b0110, 4'b0000, TRANS_SEQ,    BURST_INCR8,  1'b1, 1, 4'b0010, 1, 2'd1, 1'b0);
    applyStimulus("incr8_b7",  4'b0110, 4'b0000, TRANS_SEQ,    BURST_INCR8,  1'b1, 1, 4'b0010, 1, 2'd1, 1'b0);
    applyStimulus("incr8_b8",  4'b0110, 4'b0000, TRANS_SEQ,    BURST_INCR8,  1'b1, 1, 4'b0100, 1, 2'd1, 1'b0);
    applyStimulus("m2_master2",4'b0100, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1'b1, 1, 4'b0100, 1, 2'd2, 1'b0);

    applyStimulus("incr16_b1", 4'b0100, 4'b0000, TRANS_NONSEQ, BURST_INCR16, 1'b1, 1, 4'b0100, 1, 2'd2, 1'b0);
    applyStimulus("incr16_b2", 4'b0100, 4'b0000, TRANS_SEQ,    BURST_INCR16, 1'b1, 0, 4'b0000, 0, 2'd0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    sb.push_back('{cyc_count, "async_reset", 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0});
    @(posedge clk);
    #1;
    bus.HBUSREQ = 4'b0000;
    bus.HTRANS  = TRANS_IDLE;
    bus.HBURST  = BURST_SINGLE;
    rst = 1'b0;
    applyStimulus("post_reset_req", 4'b0100, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, 1, 4'b0100, 1, 2'd0, 1'b0);
    applyStimulus("post_reset_own", 4'b0100, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, 1, 4'b0100, 1, 2'd2, 1'b0);
    applyStimulus("post_reset_single", 4'b0100, 4'b0000, TRANS_NONSEQ, BURST_SINGLE, 1'b1, 1, 4'b0100, 1, 2'd2, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

Round-robin AHB bus arbiter that shares the single AHB master port of the bridge subsystem between up to `NUM_MASTERS` requesting masters. It samples the shared HTRANS/HBURST/HREADY bus, tracks burst progress and hands over ownership only at legal burst boundaries. It honours HLOCK and drives HGRANT, HMASTER and HMASTLOCK to the address/data multiplexers in front of the ahb2apb bridge.

## Interface
Parameters:
- `NUM_MASTERS`, default 4: number of requesters, range 2..16.
- `DEFAULT_MASTER`, default 0: master granted when nobody requests, and after reset.
- `MW`, default `$clog2(NUM_MASTERS)`: HMASTER width. Derived; not overridden.

Ports:
- `HCLK`, in, 1: bus clock. One clock; all state is on the rising edge.
- `HRESET`, in, 1: reset, asynchronous and active-high.
- `HBUSREQ`, in, NUM_MASTERS: per-master bus request.
- `HLOCK`, in, NUM_MASTERS: per-master locked-transfer request.
- `HTRANS`, in, 2: shared bus transfer type, using the `trans_type_t` encoding.
- `HBURST`, in, 3: shared bus burst type, using the `burst_type_t` encoding.
- `HREADY`, in, 1: shared bus ready.
- `HGRANT`, out, NUM_MASTERS: one-hot grant, registered.
- `HMASTER`, out, MW: index of the current address-phase owner, registered.
- `HMASTLOCK`, out, 1: the current address phase is locked, registered.

## Operation
- Beat count per HBURST: SINGLE=1; INCR4/WRAP4=4; INCR8/WRAP8=8; INCR16/WRAP16=16; INCR=undefined length.
- Remaining-beat counter `rem` (5 bits, reset 0). It updates only on a rising edge with HREADY=1:
  - NONSEQ with a fixed burst: `rem <= beats-1`, and `undef` is cleared.
  - NONSEQ with INCR: `rem <= 0`, and `undef` is set.
  - SEQ with rem>0: `rem <= rem-1`.
  - IDLE: `rem <= 0`, and `undef` is cleared.
  - BUSY: no change.
- Arbitration point is a rising edge with HREADY=1 and HTRANS!=BUSY where either:
  - `undef`=0 and the next value of rem is 0, or
  - `undef`=1 and `HBUSREQ[owner]`=0.
- Owner means the master currently granted (HGRANT).
- At an arbitration point:
  - If `HLOCK[owner]` and `HBUSREQ[owner]` are both high, the owner keeps the grant.
  - Otherwise, if any HBUSREQ is set, grant the first requester searching circularly from owner+1. The owner is searched last, so a sole requester re-wins.
  - Otherwise grant DEFAULT_MASTER.
- Outside arbitration points HGRANT holds.
- HMASTER/HMASTLOCK: on every rising edge with HREADY=1, `HMASTER <= index(HGRANT)` and `HMASTLOCK <= HLOCK[index(HGRANT)]`. With HREADY=0 both hold.
- HGRANT is always exactly one-hot. No state changes while HREADY=0.
- Undefined-length INCR is never pre-empted; the owner keeps the bus until it drops HBUSREQ.

## Timing
- Reset values (asynchronous):
  - HGRANT = one-hot(DEFAULT_MASTER).
  - HMASTER = DEFAULT_MASTER.
  - HMASTLOCK = 0.
  - rem = 0, undef = 0.
  - Round-robin pointer = DEFAULT_MASTER.
- Reset asserted mid-burst returns everything to reset values immediately. The first arbitration happens at the first HREADY=1 edge after deassertion.
- Handover latency:
  - HGRANT changes on the edge that accepts the last address beat.
  - HMASTER follows on the next HREADY=1 edge.
  - The result is one bus cycle (expected IDLE) between the old owner's last beat and the new owner's NONSEQ.
- Request-to-grant latency on an idle bus: 1 cycle from HBUSREQ rising to HGRANT, when HREADY=1.
- HREADY low on the arbitration cycle postpones the arbitration to the next HREADY=1 edge, using the request values sampled then.
- A simultaneous request from all masters is resolved by round-robin order only. There is no fixed priority apart from DEFAULT_MASTER parking.
- rem never underflows: SEQ with rem=0 leaves it at 0.

## Structure
- `ahb_apb_bridge_pkg` gains:
  - `beats_t` (5-bit).
  - Function `burst_beats(burst_type_t)`, returning 1/4/8/16, with 0 meaning undefined.
  - Reuses the existing `trans_type_t` and `burst_type_t`.
- One sub-module, `rr_pick`: a combinational circular first-one finder with inputs (req vector, start index) and outputs (found, index), parameterised by NUM_MASTERS.
- The top level holds the counter, the undef flag, the grant/master registers and the lock logic.

## Test plan
- Reset, no requests, HREADY=1: HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0 held for 10 cycles.
- M1 requests; M1 runs INCR4 (NONSEQ + 3 SEQ, HREADY=1) while M2 requests from the first beat:
  - HGRANT stays 4'b0010 until the 4th beat edge, then becomes 4'b0100.
  - HMASTER=2 one HREADY-edge later.
- All four request continuously, SINGLE transfers: grants rotate 0→1→2→3→0 on successive arbitration points.
- M3 holds HLOCK with HBUSREQ through two INCR8 bursts while M0 requests:
  - HGRANT stays 4'b1000 and HMASTLOCK=1.
  - The grant passes to M0 only after M3 drops HLOCK at a burst end.
- INCR8 from M1 with HREADY=0 for 3 cycles on beat 5 and a BUSY cycle on beat 6: grant still switches only after the 8th accepted beat.
- HRESET pulsed on beat 2 of M2's INCR16: outputs return to reset values asynchronously; the next request from M2 is granted normally.
